// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t  - two-state transmitter FSM encoding (IDLE, SHIFT)
//   cnt_w()  - bit-counter width for a given word width, never below 1
package piso_pkg;

    // Legal word-width range of the serializer.
    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A 1-bit word still needs a 1-bit counter: $clog2(1) is 0, which
    // would give a zero-width vector.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter for the serializer; raises tc at position WIDTH-1.
// Latency: count updates one clk edge after inc/clr; tc is combinational from the count.
// Backpressure: none; inc is ignored once the terminal count is reached (no wrap).
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset, clears the count
//   inc    - advance by one (held at WIDTH-1 once reached)
//   clr    - synchronous clear, takes priority over inc
//   cnt    - current bit position
//   tc     - terminal count, cnt == WIDTH-1
module bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     clr,
    output logic [cnt_w(WIDTH)-1:0]  cnt,
    output logic                     tc
);

    localparam int            CW     = cnt_w(WIDTH);
    localparam logic [CW-1:0] TC_VAL = CW'(WIDTH - 1);

    assign tc = (cnt == TC_VAL);

    // Saturating at TC_VAL keeps the count inside the word; for WIDTH=1 the
    // counter therefore never leaves 0 and tc is permanently high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word on a valid/ready load and emits one bit per en edge.
// Latency: first bit on dout the cycle after the accepting edge; a word occupies WIDTH enabled edges.
// Backpressure: load_ready only when idle or on the last bit (back-to-back, no bubble); low whenever en=0.
//
// Parameters:
//   WIDTH      - word width in bits, 1..32
//   MSB_FIRST  - 1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
// Ports:
//   clk         - clock, rising edge
//   rst_n       - synchronous active-low reset (wins over en and load_valid)
//   en          - clock enable shared with the downstream 1-bit chains
//   load_valid  - load_data is offered
//   load_data   - word to serialize, sampled only on an accepted edge
//   load_ready  - a word can be accepted on this edge (combinational)
//   dout        - current serial bit, 0 while idle
//   dout_valid  - dout carries a bit of a word this cycle
//   last        - dout is the final bit of the current word
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             in_shift;
    logic             accept;
    logic             word_done;
    logic             cnt_clr;
    logic             cnt_inc;

    assign in_shift = (state == SHIFT);

    // Ready during the last bit lets the next word follow with no gap.
    // en gates everything so a stalled edge can never take a word.
    assign load_ready = en & (~in_shift | tc);
    assign accept     = load_valid & load_ready;

    // The final bit has been consumed on this edge.
    assign word_done = en & in_shift & tc;

    // Clearing on word_done as well as accept leaves the counter at 0 in IDLE.
    assign cnt_clr = accept | word_done;
    assign cnt_inc = en & in_shift;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (cnt),
        .tc    (tc)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A reload on the last-bit edge keeps the FSM in SHIFT.
                if (word_done) begin
                    state_nxt = accept ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        last       = 1'b0;
        if (in_shift) begin
            dout_valid = 1'b1;
            last       = tc;
            dout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        end
    end

    // ------------------------------------------------------------------
    // Shift register
    // ------------------------------------------------------------------
    // The register moves toward the output end with zero fill, so after the
    // last bit it is already mostly zero; it is cleared outright on
    // word_done so IDLE always holds 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (accept) begin
            sreg <= load_data;
        end else if (en && in_shift) begin
            if (tc) begin
                sreg <= '0;
            end else if (MSB_FIRST) begin
                sreg <= sreg << 1;
            end else begin
                sreg <= sreg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: WIDTH=8 in both bit orders driven in
// lock-step from one load port, plus a WIDTH=1 LSB-first instance.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load_valid;
    logic [7:0] load_data;

    // WIDTH=8, MSB first
    logic load_ready, dout, dout_valid, last;
    // WIDTH=8, LSB first, same load stream
    logic lr_l, do_l, dv_l, la_l;
    // WIDTH=1, LSB first
    logic       lv1;
    logic [0:0] ld1;
    logic       lr1, do1, dv1, la1;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .last       (last)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (lr_l),
        .dout       (do_l),
        .dout_valid (dv_l),
        .last       (la_l)
    );

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) dut_w1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (lv1),
        .load_data  (ld1),
        .load_ready (lr1),
        .dout       (do1),
        .dout_valid (dv1),
        .last       (la1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling/driving.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One cycle of both WIDTH=8 instances.
    task automatic cyc(input string tag, input logic bm, input logic bl,
                       input logic v, input logic l);
        chk({tag, ".dout_msb"},  dout,       bm);
        chk({tag, ".dout_lsb"},  do_l,       bl);
        chk({tag, ".valid_msb"}, dout_valid, v);
        chk({tag, ".valid_lsb"}, dv_l,       v);
        chk({tag, ".last_msb"},  last,       l);
        chk({tag, ".last_lsb"},  la_l,       l);
    endtask

    // Check all eight bit cycles of a word, ticking after each.
    task automatic word(input string tag, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("%s[%0d]", tag, i), w[7-i], w[i], 1'b1, i == 7);
            tick;
        end
    endtask

    // One-edge load offer from idle.
    task automatic load(input string tag, input logic [7:0] w);
        load_valid = 1'b1;
        load_data  = w;
        #1;
        chk({tag, ".ready"}, {31'd0, load_ready}, 32'd1);
        tick;
        load_valid = 1'b0;
        load_data  = 8'h00;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        lv1        = 1'b0;
        ld1        = 1'b0;

        // Reset with a live offer: reset wins, nothing accepted.
        tick;
        cyc("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        cyc("rst1", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n      = 1'b1;
        load_valid = 1'b0;
        #1;
        chk("rst.ready_msb", {31'd0, load_ready}, 32'd1);
        chk("rst.ready_lsb", {31'd0, lr_l}, 32'd1);
        chk("rst.ready_w1",  {31'd0, lr1}, 32'd1);
        cyc("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single word A5.
        load("a5", 8'hA5);
        chk("a5.busy_ready", {31'd0, load_ready}, 32'd0);
        word("a5", 8'hA5);
        cyc("a5.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5.idle_ready", {31'd0, load_ready}, 32'd1);

        // Back-to-back A5 then 3C: 3C offered all through the first word.
        load_valid = 1'b1;
        load_data  = 8'hA5;
        tick;
        load_data  = 8'h3C;
        word("b2b_a", 8'hA5);
        load_valid = 1'b0;
        word("b2b_b", 8'h3C);
        cyc("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // en stall of 3 cycles while bit index 1 of F0 is on dout.
        load("f0", 8'hF0);
        cyc("f0[0]", 1'b1, 1'b0, 1'b1, 1'b0);
        tick;
        cyc("f0[1]", 1'b1, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h55;
        #1;
        chk("stall.ready_msb", {31'd0, load_ready}, 32'd0);
        chk("stall.ready_lsb", {31'd0, lr_l}, 32'd0);
        for (int s = 0; s < 3; s++) begin
            tick;
            cyc($sformatf("stall%0d", s), 1'b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("stall%0d.ready", s), {31'd0, load_ready}, 32'd0);
        end
        en = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        for (int i = 2; i < 8; i++) begin
            tick;
            cyc($sformatf("f0[%0d]", i), 1'b1 ^ (i >= 4), 1'b0 ^ (i >= 4), 1'b1, i == 7);
        end
        tick;
        cyc("f0.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset after bit 4 of FF abandons the word.
        load("ff", 8'hFF);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("ff[%0d]", i), 1'b1, 1'b1, 1'b1, 1'b0);
            if (i < 3) tick;
        end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        #1;
        cyc("ff.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ff.rst_ready", {31'd0, load_ready}, 32'd1);
        load("x01", 8'h01);
        word("x01", 8'h01);
        cyc("x01.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // WIDTH=1: 1 then 0 back-to-back, last on every bit.
        lv1 = 1'b1;
        ld1 = 1'b1;
        tick;
        ld1 = 1'b0;
        chk("w1[0].dout",  {31'd0, do1}, 32'd1);
        chk("w1[0].valid", {31'd0, dv1}, 32'd1);
        chk("w1[0].last",  {31'd0, la1}, 32'd1);
        chk("w1[0].ready", {31'd0, lr1}, 32'd1);
        tick;
        lv1 = 1'b0;
        chk("w1[1].dout",  {31'd0, do1}, 32'd0);
        chk("w1[1].valid", {31'd0, dv1}, 32'd1);
        chk("w1[1].last",  {31'd0, la1}, 32'd1);
        tick;
        chk("w1.idle_valid", {31'd0, dv1}, 32'd0);
        chk("w1.idle_last",  {31'd0, la1}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per enabled clock. Sits in front of the team's 1-bit enabled storage and shift-register chains, which sample `dout` on their `din` using the same `en` qualifier. Supports back-to-back words with no idle bubble and a selectable bit order.

## Interface
- WIDTH, 8, word width in bits; legal range 1..32.
- MSB_FIRST, 1, 1: bit WIDTH-1 is transmitted first; 0: bit 0 is transmitted first.

- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  clock enable; state advances only on edges where en=1.
- load_valid  input  1  load_data is presented for transfer.
- load_data  input  WIDTH  word to serialize; sampled only on an accepted edge.
- load_ready  output  1  block can accept a word on this edge.
- dout  output  1  current serial bit.
- dout_valid  output  1  dout carries a valid bit this cycle.
- last  output  1  dout is the final bit of the current word.

## Operation
- States: IDLE, SHIFT.
- Registers: shift register sreg[WIDTH-1:0], bit counter cnt of width max(1, clog2(WIDTH)), state.
- Reset (rst_n=0 on an edge, regardless of en): state=IDLE, sreg=0, cnt=0. Outputs after reset: dout=0, dout_valid=0, last=0, load_ready=en.
- load_ready = en AND (state==IDLE OR (state==SHIFT AND cnt==WIDTH-1)). It is combinational from state and en.
- Accept = load_valid AND load_ready on a rising edge. On accept: sreg<=load_data, cnt<=0, state<=SHIFT.
- dout = sreg[WIDTH-1] if MSB_FIRST, else sreg[0]. dout is 0 in IDLE.
- dout_valid = (state==SHIFT).
- last = (state==SHIFT AND cnt==WIDTH-1).
- SHIFT with en=1, not last: shift sreg by one toward the output end, zero-filling; cnt<=cnt+1.
- SHIFT with en=1, last:
  - If accept occurs, reload and stay in SHIFT.
  - Otherwise go to IDLE and clear sreg.
- en=0: all registers hold; load_ready=0, so no accept can occur.
- WIDTH=1: cnt is stuck at 0, so last equals dout_valid and every SHIFT cycle is a last-bit cycle.
- The counter never exceeds WIDTH-1; there is no wrap-around past the word boundary.

## Timing
- Latency: first bit on dout in the cycle after the accepting edge.
- Each bit is held until the next en=1 edge. With en tied high, a word occupies exactly WIDTH cycles.
- Back-to-back: an accept on the last-bit edge places bit 0 of the new word on dout the next cycle, with no dout_valid gap.
- The producer must hold load_valid and load_data stable until accepted. Dropping load_valid before acceptance is legal and discards the offer.
- Reset mid-word: the word is abandoned. The next cycle shows dout_valid=0 and a fresh handshake is required.
- Reset and load_valid on the same edge: reset wins and nothing is accepted.

## Structure
- Shared package `piso_pkg`:
  - state enum {IDLE, SHIFT}.
  - function cnt_w(WIDTH) returning max(1, clog2(WIDTH)).
- Sub-module `bit_counter`: up-counter with synchronous active-low reset, enable, synchronous clear, and a terminal-count output at WIDTH-1. It drives both last and load_ready.
- The FSM and shift register remain in the top module.

## Test plan
- Reset: hold rst_n=0 for 2 edges with load_valid=1 -> dout=0, dout_valid=0, last=0, no accept. Release -> load_ready=1 with en=1.
- MSB_FIRST=1, WIDTH=8, load 8'hA5, en=1 -> dout=1,0,1,0,0,1,0,1 on cycles 1..8, last only on cycle 8, then IDLE.
- Back-to-back: load 8'hA5, then 8'h3C offered continuously -> 16 consecutive dout_valid cycles: 10100101 then 00111100, with last on cycles 8 and 16.
- en stall: load 8'hF0, drop en for 3 cycles after bit 2 -> dout, dout_valid and cnt hold, load_ready=0, stream resumes correctly.
- Reset mid-word: assert rst_n=0 after bit 4 of 8'hFF -> next cycle dout_valid=0, dout=0. A new load of 8'h01 transmits 0000_0001.
- MSB_FIRST=0, WIDTH=1: load 1'b1, then 1'b0 back-to-back -> dout=1,0 with last=1 on both cycles.
